// File: rtl/teclado_clave_param.sv
// teclado_clave_param
// Keypad password checker. Collects a sequence of N_DIGITS decimal keys and
// compares it against PASSWORD when enter is pressed. Counts failed attempts
// and locks the keypad after MAX_INTENTOS failures.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   teclas[9:0]  in   key levels, bit i = digit i (already synchronised)
//   enter        in   enter key level
//   verificacion out  high while unlocked
//   error        out  one-cycle pulse per rejected attempt
//   bloqueo      out  high while locked out
//   intentos     out  failed attempts since last success/reset/lockout expiry
//   digitos      out  digits entered in the current attempt (saturating)
//
// Build option: define TECLADO_BLOQUEO_PERM_EN for a permanent lockout that
// only rst clears; the lockout timer is then not built.
//
// state   | meaning
// INGRESO | collecting digits, waiting for enter
// ABIERTO | password accepted, verificacion high
// BLOQUEO | too many failures, all input ignored
module teclado_clave_param #(
   parameter int                      N_DIGITS     = 4,
   parameter logic [4*N_DIGITS-1:0]   PASSWORD     = 16'h4321,
   parameter int                      MAX_INTENTOS = 3,
   parameter int                      LOCK_CYCLES  = 16,
   localparam int                     DW = $clog2(N_DIGITS + 1),
   localparam int                     IW = $clog2(MAX_INTENTOS + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [9:0]    teclas,
   input  logic          enter,
   output logic          verificacion,
   output logic          error,
   output logic          bloqueo,
   output logic [IW-1:0] intentos,
   output logic [DW-1:0] digitos
);

   typedef enum logic [1:0] {INGRESO, ABIERTO, BLOQUEO} estado_t;

   localparam logic [DW-1:0] N_D   = DW'(N_DIGITS);
   localparam logic [IW-1:0] MAX_I = IW'(MAX_INTENTOS);
   localparam logic [3:0]    PW0   = PASSWORD[4*N_DIGITS-1 -: 4];

   estado_t       state_q;
   logic [9:0]    teclas_q;
   logic          enter_q;
   logic [DW-1:0] digitos_q;
   logic          mal_q;
   logic [IW-1:0] intentos_q;
   logic          verif_q;
   logic          error_q;
   logic          bloqueo_q;

`ifndef TECLADO_BLOQUEO_PERM_EN
   localparam int CW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   logic [CW-1:0] cnt_q;
`endif

   logic [9:0]    tec_edge;
   logic          ent_edge;
   logic          tec_valido;
   logic [3:0]    key_val;
   logic [3:0]    exp_dig;
   logic [DW-1:0] digitos_d;
   logic          mal_d;

   // Buffer after applying this cycle's key press; enter in the same cycle
   // evaluates this updated view.
   always_comb begin
      tec_edge   = teclas & ~teclas_q;
      ent_edge   = enter & ~enter_q;
      tec_valido = (tec_edge != 10'd0) && ((tec_edge & (tec_edge - 10'd1)) == 10'd0);
      key_val    = 4'd0;
      for (int i = 0; i < 10; i++)
         if (tec_edge[i]) key_val = 4'(i);
      exp_dig = 4'd0;
      for (int i = 0; i < N_DIGITS; i++)
         if (digitos_q == DW'(i)) exp_dig = PASSWORD[4*(N_DIGITS-1-i) +: 4];
      digitos_d = digitos_q;
      mal_d     = mal_q;
      if (tec_valido) begin
         if (digitos_q == N_D) begin
            mal_d = 1'b1;
         end else begin
            digitos_d = digitos_q + DW'(1);
            if (key_val != exp_dig) mal_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         teclas_q   <= teclas;
         enter_q    <= enter;
         state_q    <= INGRESO;
         digitos_q  <= '0;
         mal_q      <= 1'b0;
         intentos_q <= '0;
         verif_q    <= 1'b0;
         error_q    <= 1'b0;
         bloqueo_q  <= 1'b0;
`ifndef TECLADO_BLOQUEO_PERM_EN
         cnt_q      <= '0;
`endif
      end else begin
         teclas_q <= teclas;
         enter_q  <= enter;
         error_q  <= 1'b0;
         case (state_q)
            INGRESO: begin
               if (ent_edge && (digitos_d != '0)) begin
                  digitos_q <= '0;
                  mal_q     <= 1'b0;
                  if ((digitos_d == N_D) && !mal_d) begin
                     state_q    <= ABIERTO;
                     verif_q    <= 1'b1;
                     intentos_q <= '0;
                  end else begin
                     error_q    <= 1'b1;
                     intentos_q <= intentos_q + IW'(1);
                     if (intentos_q + IW'(1) == MAX_I) begin
                        state_q   <= BLOQUEO;
                        bloqueo_q <= 1'b1;
`ifndef TECLADO_BLOQUEO_PERM_EN
                        cnt_q     <= CW'(LOCK_CYCLES - 1);
`endif
                     end
                  end
               end else begin
                  digitos_q <= digitos_d;
                  mal_q     <= mal_d;
               end
            end
            ABIERTO: begin
               // A new press starts the next attempt as its first digit.
               if (tec_valido) begin
                  state_q   <= INGRESO;
                  verif_q   <= 1'b0;
                  digitos_q <= DW'(1);
                  mal_q     <= (key_val != PW0);
               end
            end
            BLOQUEO: begin
`ifndef TECLADO_BLOQUEO_PERM_EN
               if (cnt_q == '0) begin
                  state_q    <= INGRESO;
                  bloqueo_q  <= 1'b0;
                  intentos_q <= '0;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
`endif
            end
            default: begin
               state_q <= INGRESO;
            end
         endcase
      end
   end

   assign verificacion = verif_q;
   assign error        = error_q;
   assign bloqueo      = bloqueo_q;
   assign intentos     = intentos_q;
   assign digitos      = digitos_q;

endmodule

// File: tb/tb_teclado_clave_param.sv
// Directed bench for teclado_clave_param with default parameters.
// Follows TECLADO_BLOQUEO_PERM_EN for the lockout section.
module tb_teclado_clave_param;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] teclas;
   logic       enter;
   logic       verificacion;
   logic       error;
   logic       bloqueo;
   logic [1:0] intentos;
   logic [2:0] digitos;

   int n_vec = 0;
   int n_err = 0;

   teclado_clave_param dut (
      .clk          (clk),
      .rst          (rst),
      .teclas       (teclas),
      .enter        (enter),
      .verificacion (verificacion),
      .error        (error),
      .bloqueo      (bloqueo),
      .intentos     (intentos),
      .digitos      (digitos)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input int d);
      teclas = 10'd1 << d;
      tick();
      teclas = 10'd0;
      tick();
   endtask

   task automatic enter_on();
      enter = 1'b1;
      tick();
   endtask

   task automatic enter_off();
      enter = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int n_hi;
      rst    = 1'b1;
      teclas = 10'd0;
      enter  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check_val("rst_verif", verificacion, 0);
      check_val("rst_error", error, 0);
      check_val("rst_bloqueo", bloqueo, 0);
      check_val("rst_intentos", intentos, 0);
      check_val("rst_digitos", digitos, 0);

      // correct entry 4,3,2,1
      press(4); check_val("ok_dig1", digitos, 1);
      press(3); check_val("ok_dig2", digitos, 2);
      press(2); check_val("ok_dig3", digitos, 3);
      press(1); check_val("ok_dig4", digitos, 4);
      enter_on();
      check_val("ok_verif", verificacion, 1);
      check_val("ok_error", error, 0);
      check_val("ok_intentos", intentos, 0);
      check_val("ok_dig_clr", digitos, 0);
      enter_off();

      // wrong then correct; first press leaves ABIERTO
      press(7);
      check_val("w_leave_verif", verificacion, 0);
      check_val("w_dig1", digitos, 1);
      press(2); press(3); press(1);
      enter_on();
      check_val("w_error", error, 1);
      check_val("w_intentos", intentos, 1);
      check_val("w_verif", verificacion, 0);
      enter_off();
      check_val("w_error_1cyc", error, 0);
      press(4); press(3); press(2); press(1);
      enter_on();
      check_val("w2_verif", verificacion, 1);
      check_val("w2_intentos", intentos, 0);
      enter_off();

      // length errors then lockout
      press(7); press(2); press(3); press(1); press(2);
      check_val("len_sat", digitos, 4);
      enter_on();
      check_val("len5_error", error, 1);
      check_val("len5_intentos", intentos, 1);
      enter_off();
      press(2); press(2); press(2); press(2);
      enter_on();
      check_val("bad_error", error, 1);
      check_val("bad_intentos", intentos, 2);
      enter_off();
      press(9);
      enter_on();
      check_val("short_error", error, 1);
      check_val("short_intentos", intentos, 3);
      check_val("lock_on", bloqueo, 1);
      enter = 1'b0;
`ifdef TECLADO_BLOQUEO_PERM_EN
      n_hi = 0;
      for (int i = 0; i < 120; i++) begin
         teclas = i[0] ? 10'h010 : 10'h000;
         tick();
         if (!bloqueo) n_hi++;
      end
      teclas = 10'd0;
      check_val("perm_low_cycles", n_hi, 0);
      check_val("perm_dig", digitos, 0);
      do_reset();
      check_val("perm_rst_bloqueo", bloqueo, 0);
      check_val("perm_rst_intentos", intentos, 0);
`else
      n_hi = 1;
      for (int i = 1; i <= 40; i++) begin
         teclas = i[0] ? 10'h010 : 10'h000;
         tick();
         if (!bloqueo) break;
         n_hi++;
      end
      check_val("lock_len", n_hi, 16);
      check_val("lock_dig", digitos, 0);
      check_val("lock_intentos", intentos, 0);
      teclas = 10'd0;
      tick();
`endif
      press(4); press(3); press(2); press(1);
      enter_on();
      check_val("after_lock_verif", verificacion, 1);
      enter_off();

      // input corner cases
      do_reset();
      teclas = 10'h018;
      tick();
      check_val("multi_key", digitos, 0);
      teclas = 10'd0;
      tick();
      press(5);
      enter_on();
      enter_off();
      check_val("pre_empty_int", intentos, 1);
      enter_on();
      check_val("empty_error", error, 0);
      check_val("empty_intentos", intentos, 1);
      enter_off();
      press(4); press(3); press(2);
      teclas = 10'h002;
      enter  = 1'b1;
      tick();
      check_val("same_cyc_verif", verificacion, 1);
      check_val("same_cyc_int", intentos, 0);
      teclas = 10'd0;
      enter_off();

      // reset mid-operation
      press(4); press(3);
      check_val("mid_dig2", digitos, 2);
      do_reset();
      check_val("mid_rst_dig", digitos, 0);
      check_val("mid_rst_verif", verificacion, 0);
      for (int k = 0; k < 3; k++) begin
         press(9);
         enter_on();
         enter_off();
      end
      check_val("rl_bloqueo", bloqueo, 1);
      do_reset();
      check_val("rl_rst_bloqueo", bloqueo, 0);
      check_val("rl_rst_intentos", intentos, 0);
      rst    = 1'b1;
      teclas = 10'h010;
      tick();
      rst = 1'b0;
      tick();
      tick();
      check_val("held_key", digitos, 0);
      teclas = 10'd0;
      tick();
      press(4);
      check_val("after_held", digitos, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
